// File: rtl/crg_pkg.sv
// Shared types and encodings for the clock-gate controller.
package crg_pkg;

    typedef enum logic [1:0] {
        ST_ON       = 2'd0,
        ST_IDLE_CNT = 2'd1,
        ST_OFF      = 2'd2,
        ST_WAKE     = 2'd3
    } crg_state_e;

    // Clock-gate cell operation select
    localparam logic [1:0] CG_SEL_EN  = 2'b00;
    localparam logic [1:0] CG_SEL_BP  = 2'b01;
    localparam logic [1:0] CG_SEL_DIS = 2'b10;

    // Configuration mode encodings
    localparam logic [1:0] MODE_AUTO      = 2'b00;
    localparam logic [1:0] MODE_FORCE_ON  = 2'b01;
    localparam logic [1:0] MODE_FORCE_OFF = 2'b10;
    localparam logic [1:0] MODE_RSVD      = 2'b11;

    // Reserved mode falls back to enable-driven gating, same as auto.
    function automatic logic [1:0] mode_to_cg_sel(input logic [1:0] mode);
        logic [1:0] sel;
        case (mode)
            MODE_AUTO:      sel = CG_SEL_EN;
            MODE_FORCE_ON:  sel = CG_SEL_BP;
            MODE_FORCE_OFF: sel = CG_SEL_DIS;
            default:        sel = CG_SEL_EN;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/crg_sat_cnt.sv
// Saturating up-counter: counts inc pulses and holds at all-ones.
module crg_sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    localparam logic [W-1:0] CNT_MAX = {W{1'b1}};
    localparam logic [W-1:0] CNT_ONE = W'(1);

    // Count up on inc until the ceiling is reached, then hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= {W{1'b0}};
        end else if (inc && (cnt != CNT_MAX)) begin
            cnt <= cnt + CNT_ONE;
        end else begin
            cnt <= cnt;
        end
    end

endmodule

// File: rtl/crg_clk_gate_ctrl.sv
// Idle-driven clock-gate controller with wake handshake.
// WAKE_CYC is expected to be at least 1; a value of 0 behaves like 1.
module crg_clk_gate_ctrl
    import crg_pkg::*;
#(
    parameter int IDLE_W   = 8,
    parameter int WAKE_CYC = 2,
    parameter int EVT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        cfg_mode,
    input  logic [IDLE_W-1:0] cfg_idle_thr,
    input  logic              busy,
    input  logic              wake_req,
    output logic              wake_ack,
    output logic              clk_en,
    output logic [1:0]        cg_sel,
    output logic              gated,
    output logic [EVT_W-1:0]  gate_evt_cnt
);

    localparam int WAKE_W = (WAKE_CYC > 1) ? $clog2(WAKE_CYC) : 1;
    localparam logic [WAKE_W-1:0] WAKE_LOAD = WAKE_W'((WAKE_CYC > 0) ? (WAKE_CYC - 1) : 0);
    localparam logic [WAKE_W-1:0] WAKE_ONE  = WAKE_W'(1);
    localparam logic [IDLE_W-1:0] IDLE_ONE  = IDLE_W'(1);
    localparam logic [IDLE_W-1:0] IDLE_ZERO = {IDLE_W{1'b0}};

    crg_state_e        state_r;
    logic [IDLE_W-1:0] idle_cnt_r;
    logic [WAKE_W-1:0] wake_cnt_r;
    logic              ack_done_r;
    logic              wake_ack_r;
    logic              clk_en_r;
    logic              gated_r;
    logic [1:0]        cg_sel_r;

    logic idle_s;
    logic gate_evt_s;
    logic ack_now_s;

    // Decode idle, the IDLE_CNT->OFF event and whether a wake_ack is due.
    always_comb begin
        idle_s     = 1'b0;
        gate_evt_s = 1'b0;
        ack_now_s  = 1'b0;
        idle_s = ~busy & ~wake_req;
        if ((state_r == ST_IDLE_CNT) && idle_s && (idle_cnt_r == IDLE_ZERO)) begin
            gate_evt_s = 1'b1;
        end else begin
            gate_evt_s = 1'b0;
        end
        // One ack per wake_req assertion; ack_done_r re-arms when wake_req drops.
        if (wake_req && !ack_done_r) begin
            case (state_r)
                ST_ON:       ack_now_s = 1'b1;
                ST_IDLE_CNT: ack_now_s = 1'b1;
                ST_WAKE:     ack_now_s = (wake_cnt_r == {WAKE_W{1'b0}});
                default:     ack_now_s = 1'b0;
            endcase
        end else begin
            ack_now_s = 1'b0;
        end
    end

    // Main FSM: state, counters and registered clk_en/gated/wake_ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_ON;
            idle_cnt_r <= IDLE_ZERO;
            wake_cnt_r <= {WAKE_W{1'b0}};
            ack_done_r <= 1'b0;
            wake_ack_r <= 1'b0;
            clk_en_r   <= 1'b1;
            gated_r    <= 1'b0;
        end else begin
            wake_ack_r <= ack_now_s;
            ack_done_r <= wake_req & (ack_done_r | ack_now_s);
            case (state_r)
                ST_ON: begin
                    if (!idle_s) begin
                        state_r <= ST_ON;
                    end else if (cfg_idle_thr != IDLE_ZERO) begin
                        state_r    <= ST_IDLE_CNT;
                        idle_cnt_r <= cfg_idle_thr - IDLE_ONE;
                    end else begin
                        state_r <= ST_ON;
                    end
                end
                ST_IDLE_CNT: begin
                    // Activity or a wake request beats an expiring threshold.
                    if (!idle_s) begin
                        state_r    <= ST_ON;
                        idle_cnt_r <= IDLE_ZERO;
                    end else if (idle_cnt_r == IDLE_ZERO) begin
                        state_r  <= ST_OFF;
                        clk_en_r <= 1'b0;
                        gated_r  <= 1'b1;
                    end else begin
                        idle_cnt_r <= idle_cnt_r - IDLE_ONE;
                    end
                end
                ST_OFF: begin
                    if (busy || wake_req) begin
                        state_r    <= ST_WAKE;
                        wake_cnt_r <= WAKE_LOAD;
                        clk_en_r   <= 1'b1;
                        gated_r    <= 1'b0;
                    end else begin
                        state_r <= ST_OFF;
                    end
                end
                ST_WAKE: begin
                    if (wake_cnt_r == {WAKE_W{1'b0}}) begin
                        state_r <= ST_ON;
                    end else begin
                        wake_cnt_r <= wake_cnt_r - WAKE_ONE;
                    end
                end
                default: begin
                    state_r  <= ST_ON;
                    clk_en_r <= 1'b1;
                    gated_r  <= 1'b0;
                end
            endcase
        end
    end

    // Gate-cell select follows cfg_mode one cycle later; bypass while in reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cg_sel_r <= CG_SEL_BP;
        end else begin
            cg_sel_r <= mode_to_cg_sel(cfg_mode);
        end
    end

    crg_sat_cnt #(
        .W (EVT_W)
    ) u_evt_cnt (
        .clk (clk),
        .rst (rst),
        .inc (gate_evt_s),
        .cnt (gate_evt_cnt)
    );

    assign wake_ack = wake_ack_r;
    assign clk_en   = clk_en_r;
    assign gated    = gated_r;
    assign cg_sel   = cg_sel_r;

endmodule

// File: tb/tb_crg_clk_gate_ctrl.sv
// Directed self-checking bench for crg_clk_gate_ctrl (EVT_W=2 to reach saturation).
module tb_crg_clk_gate_ctrl;

    logic       clk;
    logic       rst;
    logic [1:0] cfg_mode;
    logic [7:0] cfg_idle_thr;
    logic       busy;
    logic       wake_req;
    logic       wake_ack;
    logic       clk_en;
    logic [1:0] cg_sel;
    logic       gated;
    logic [1:0] gate_evt_cnt;

    int checks   = 0;
    int failures = 0;

    crg_clk_gate_ctrl #(
        .IDLE_W   (8),
        .WAKE_CYC (2),
        .EVT_W    (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_mode     (cfg_mode),
        .cfg_idle_thr (cfg_idle_thr),
        .busy         (busy),
        .wake_req     (wake_req),
        .wake_ack     (wake_ack),
        .clk_en       (clk_en),
        .cg_sel       (cg_sel),
        .gated        (gated),
        .gate_evt_cnt (gate_evt_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are observed 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; cfg_mode = 2'b00; cfg_idle_thr = 8'd0; busy = 1'b1; wake_req = 1'b0;
        #1;
        checks++; if (cg_sel !== 2'b01) begin failures++; $display("FAIL rst_cg_sel: got %0b expected 01", cg_sel); end
        checks++; if (clk_en !== 1'b1) begin failures++; $display("FAIL rst_clk_en: got %0b expected 1", clk_en); end
        checks++; if (gated !== 1'b0 || wake_ack !== 1'b0) begin failures++; $display("FAIL rst_gated_ack: got %0b/%0b expected 0/0", gated, wake_ack); end
        checks++; if (gate_evt_cnt !== 2'd0) begin failures++; $display("FAIL rst_evt_cnt: got %0d expected 0", gate_evt_cnt); end
        step();
        step();
        rst = 1'b0;
        step();
        checks++; if (cg_sel !== 2'b00) begin failures++; $display("FAIL rel_cg_sel: got %0b expected 00", cg_sel); end
        checks++; if (clk_en !== 1'b1) begin failures++; $display("FAIL rel_clk_en: got %0b expected 1", clk_en); end
    endtask

    task automatic test_gate();
        cfg_idle_thr = 8'd4;
        busy = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            step();
            checks++; if (clk_en !== 1'b1) begin failures++; $display("FAIL gate_hold_%0d: clk_en got %0b expected 1", i, clk_en); end
        end
        step();
        checks++; if (clk_en !== 1'b0) begin failures++; $display("FAIL gate_fall: clk_en got %0b expected 0", clk_en); end
        checks++; if (gated !== 1'b1) begin failures++; $display("FAIL gate_gated: got %0b expected 1", gated); end
        checks++; if (gate_evt_cnt !== 2'd1) begin failures++; $display("FAIL gate_evt_cnt: got %0d expected 1", gate_evt_cnt); end
    endtask

    task automatic test_wake();
        wake_req = 1'b1;
        step();
        checks++; if (clk_en !== 1'b1 || gated !== 1'b0) begin failures++; $display("FAIL wake_clk_en: got %0b/%0b expected 1/0", clk_en, gated); end
        checks++; if (wake_ack !== 1'b0) begin failures++; $display("FAIL wake_ack_t1: got %0b expected 0", wake_ack); end
        step();
        checks++; if (wake_ack !== 1'b0) begin failures++; $display("FAIL wake_ack_t2: got %0b expected 0", wake_ack); end
        step();
        checks++; if (wake_ack !== 1'b1) begin failures++; $display("FAIL wake_ack_t3: got %0b expected 1", wake_ack); end
        step();
        checks++; if (wake_ack !== 1'b0) begin failures++; $display("FAIL wake_ack_once: got %0b expected 0", wake_ack); end
        wake_req = 1'b0; busy = 1'b1;
        step();
        wake_req = 1'b1;
        step();
        checks++; if (wake_ack !== 1'b1) begin failures++; $display("FAIL wake_on_ack: got %0b expected 1", wake_ack); end
        wake_req = 1'b0;
        step();
        checks++; if (wake_ack !== 1'b0) begin failures++; $display("FAIL wake_on_ack_end: got %0b expected 0", wake_ack); end
    endtask

    task automatic test_busy_restart();
        cfg_idle_thr = 8'd3;
        busy = 1'b0;
        step();
        busy = 1'b1;
        step();
        checks++; if (clk_en !== 1'b1) begin failures++; $display("FAIL restart_abort: clk_en got %0b expected 1", clk_en); end
        busy = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            step();
            checks++; if (clk_en !== 1'b1) begin failures++; $display("FAIL restart_hold_%0d: clk_en got %0b expected 1", i, clk_en); end
        end
        step();
        checks++; if (clk_en !== 1'b0) begin failures++; $display("FAIL restart_fall: clk_en got %0b expected 0", clk_en); end
        checks++; if (gate_evt_cnt !== 2'd2) begin failures++; $display("FAIL restart_evt_cnt: got %0d expected 2", gate_evt_cnt); end
        busy = 1'b1;
        step();
        checks++; if (clk_en !== 1'b1) begin failures++; $display("FAIL busy_wake_clk_en: got %0b expected 1", clk_en); end
        step();
        step();
        checks++; if (wake_ack !== 1'b0) begin failures++; $display("FAIL busy_wake_no_ack: got %0b expected 0", wake_ack); end
    endtask

    task automatic test_race();
        cfg_idle_thr = 8'd1;
        busy = 1'b0;
        step();
        wake_req = 1'b1;
        step();
        checks++; if (clk_en !== 1'b1 || gated !== 1'b0) begin failures++; $display("FAIL race_stay_on: got %0b/%0b expected 1/0", clk_en, gated); end
        checks++; if (wake_ack !== 1'b1) begin failures++; $display("FAIL race_ack: got %0b expected 1", wake_ack); end
        checks++; if (gate_evt_cnt !== 2'd2) begin failures++; $display("FAIL race_evt_cnt: got %0d expected 2", gate_evt_cnt); end
        wake_req = 1'b0; busy = 1'b1;
        step();
    endtask

    task automatic test_modes();
        cfg_mode = 2'b10;
        step();
        checks++; if (cg_sel !== 2'b10) begin failures++; $display("FAIL mode_dis_sel: got %0b expected 10", cg_sel); end
        cfg_idle_thr = 8'd2;
        busy = 1'b0;
        step();
        step();
        checks++; if (clk_en !== 1'b1) begin failures++; $display("FAIL dis_hold: clk_en got %0b expected 1", clk_en); end
        step();
        checks++; if (clk_en !== 1'b0 || cg_sel !== 2'b10) begin failures++; $display("FAIL dis_gate: got %0b/%0b expected 0/10", clk_en, cg_sel); end
        checks++; if (gate_evt_cnt !== 2'd3) begin failures++; $display("FAIL dis_evt_cnt: got %0d expected 3", gate_evt_cnt); end
        wake_req = 1'b1;
        step();
        checks++; if (clk_en !== 1'b1) begin failures++; $display("FAIL dis_ungate: clk_en got %0b expected 1", clk_en); end
        step();
        step();
        checks++; if (wake_ack !== 1'b1) begin failures++; $display("FAIL dis_ack: got %0b expected 1", wake_ack); end
        wake_req = 1'b0; busy = 1'b1; cfg_mode = 2'b11;
        step();
        checks++; if (cg_sel !== 2'b00) begin failures++; $display("FAIL mode_rsvd_sel: got %0b expected 00", cg_sel); end
        cfg_mode = 2'b01; cfg_idle_thr = 8'd1; busy = 1'b0;
        step();
        checks++; if (cg_sel !== 2'b01) begin failures++; $display("FAIL mode_bp_sel: got %0b expected 01", cg_sel); end
        step();
        checks++; if (clk_en !== 1'b0 || gate_evt_cnt !== 2'd3) begin failures++; $display("FAIL bp_gate: got %0b/%0d expected 0/3", clk_en, gate_evt_cnt); end
        wake_req = 1'b1;
        step();
        step();
        checks++; if (wake_ack !== 1'b0) begin failures++; $display("FAIL bp_ack_early: got %0b expected 0", wake_ack); end
        step();
        checks++; if (wake_ack !== 1'b1) begin failures++; $display("FAIL bp_ack: got %0b expected 1", wake_ack); end
        wake_req = 1'b0; busy = 1'b1; cfg_mode = 2'b00;
        step();
        cfg_idle_thr = 8'd0; busy = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            checks++; if (clk_en !== 1'b1) begin failures++; $display("FAIL thr0_hold_%0d: clk_en got %0b expected 1", i, clk_en); end
        end
    endtask

    task automatic test_saturate();
        logic [1:0] exp_cnt;
        busy = 1'b1; rst = 1'b1;
        step();
        rst = 1'b0; cfg_idle_thr = 8'd1;
        step();
        for (int i = 0; i < 5; i++) begin
            exp_cnt = (i < 3) ? 2'(i + 1) : 2'd3;
            busy = 1'b0;
            step();
            step();
            checks++; if (clk_en !== 1'b0 || gate_evt_cnt !== exp_cnt) begin failures++; $display("FAIL sat_%0d: got %0b/%0d expected 0/%0d", i, clk_en, gate_evt_cnt, exp_cnt); end
            if (i < 4) begin
                busy = 1'b1;
                step();
                step();
                step();
            end
        end
    endtask

    task automatic test_reset_mid_wake();
        wake_req = 1'b1;
        step();
        step();
        #2;
        rst = 1'b1;
        #1;
        checks++; if (clk_en !== 1'b1 || gated !== 1'b0) begin failures++; $display("FAIL mid_rst_clk_en: got %0b/%0b expected 1/0", clk_en, gated); end
        checks++; if (wake_ack !== 1'b0 || gate_evt_cnt !== 2'd0) begin failures++; $display("FAIL mid_rst_ack_cnt: got %0b/%0d expected 0/0", wake_ack, gate_evt_cnt); end
        wake_req = 1'b0;
        step();
        checks++; if (wake_ack !== 1'b0) begin failures++; $display("FAIL mid_rst_held_ack: got %0b expected 0", wake_ack); end
        rst = 1'b0;
        step();
        checks++; if (wake_ack !== 1'b0 || clk_en !== 1'b1) begin failures++; $display("FAIL mid_rst_post: got %0b/%0b expected 0/1", wake_ack, clk_en); end
        step();
        checks++; if (clk_en !== 1'b0 || gate_evt_cnt !== 2'd1) begin failures++; $display("FAIL mid_rst_regate: got %0b/%0d expected 0/1", clk_en, gate_evt_cnt); end
    endtask

    initial begin
        test_reset();
        test_gate();
        test_wake();
        test_busy_restart();
        test_race();
        test_modes();
        test_saturate();
        test_reset_mid_wake();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/crg_clk_gate_ctrl.md
CRG_CLK_GATE_CTRL -- requirements
Module: crg_clk_gate_ctrl

Interface
REQ-001 Parameter IDLE_W, default 8: width of the idle-threshold counter.
REQ-002 Parameter WAKE_CYC, default 2: settle cycles between clock re-enable and wake_ack.
REQ-003 Parameter EVT_W, default 16: width of the gate-event counter.
REQ-004 clk  in  1  free-running clock, upstream of the clock gate.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 cfg_mode  in  2  00 auto, 01 force-on (bypass), 10 force-off (disable), 11 reserved, treated as auto.
REQ-007 cfg_idle_thr  in  IDLE_W  consecutive idle cycles required before gating.
REQ-008 busy  in  1  gated-domain activity indication; idle when low.
REQ-009 wake_req  in  1  level request for the gated clock; held until wake_ack.
REQ-010 wake_ack  out  1  single-cycle pulse; gated clock is running and settled.
REQ-011 clk_en  out  1  functional enable to the clock-gate cell.
REQ-012 cg_sel  out  2  clock-gate operation select: 00 enable-driven, 01 bypass, 10 disable.
REQ-013 gated  out  1  status; high while state is OFF.
REQ-014 gate_evt_cnt  out  EVT_W  saturating count of ON->OFF transitions.

Function
REQ-015 States: ON, IDLE_CNT, OFF, WAKE; encoding is one-hot or binary, implementer's choice.
REQ-016 clk_en is high in ON, IDLE_CNT and WAKE, and low in OFF; it is driven from a flop with no combinational path from inputs.
REQ-017 cg_sel is registered from cfg_mode: 00->00, 01->01, 10->10, 11->00, with 1-cycle latency.
REQ-018 ON: if busy=0, wake_req=0 and cfg_idle_thr!=0, go to IDLE_CNT and load the counter with cfg_idle_thr-1.
REQ-019 ON with cfg_idle_thr=0: remain in ON; auto-gating is disabled.
REQ-020 IDLE_CNT: busy=1 or wake_req=1 returns to ON and clears the counter; otherwise the counter decrements, and at counter=0 the FSM goes to OFF.
REQ-021 clk_en therefore falls exactly cfg_idle_thr+1 cycles after the first idle cycle sampled in ON.
REQ-022 OFF: wake_req=1 or busy=1 moves to WAKE; clk_en rises on that transition.
REQ-023 WAKE: hold for WAKE_CYC cycles, then go to ON and pulse wake_ack for 1 cycle if wake_req is still high.
REQ-024 wake_req in ON or IDLE_CNT pulses wake_ack on the next cycle, with no settle delay.
REQ-025 wake_ack never pulses twice for one wake_req assertion; re-arming requires wake_req to be low for at least 1 cycle.
REQ-026 wake_req and an idle threshold expiring in the same cycle: wake_req wins and the FSM stays ON.
REQ-027 FSM runs in all cfg_mode values; in force-on and force-off, cg_sel overrides the gate cell regardless of clk_en.
REQ-028 In force-on, wake_ack timing is unchanged.
REQ-029 cfg_idle_thr changes take effect only at the next load into IDLE_CNT.
REQ-030 gate_evt_cnt increments on each IDLE_CNT->OFF transition and saturates at all-ones.

Reset
REQ-031 On rst assertion, asynchronously: state=ON, clk_en=1, cg_sel=01 (bypass), wake_ack=0, gated=0, gate_evt_cnt=0, idle counter=0.
REQ-032 cg_sel follows cfg_mode from the first clock edge after rst deasserts.
REQ-033 rst asserted mid-wake discards the pending wake_ack.

Structure
REQ-034 A shared package crg_pkg holds the state typedef, the cg_sel encodings (CG_SEL_EN=00, CG_SEL_BP=01, CG_SEL_DIS=10) and the cfg_mode encodings.
REQ-035 One sub-module, crg_sat_cnt (parameterised saturating counter), implements gate_evt_cnt; the rest of the logic is flat.
REQ-036 The block contains no clock-gating cells and no latches.

Verification
REQ-037 Reset release with cfg_mode=00 -> cg_sel=01 during reset, then 00 one cycle later, with clk_en=1.
REQ-038 cfg_idle_thr=4, busy drops at cycle T -> clk_en low at T+5, gated=1, gate_evt_cnt=1.
REQ-039 In OFF with WAKE_CYC=2, wake_req rises at cycle T -> clk_en high at T+1, single wake_ack pulse at T+3.
REQ-040 cfg_idle_thr=3, busy pulses high at the 2nd idle cycle -> no gating; full 4-cycle count restarts after busy falls.
REQ-041 cfg_mode=10 while idle -> cg_sel=10, FSM still gates and un-gates; cfg_idle_thr=0 -> clk_en stays 1 indefinitely.
REQ-042 EVT_W=2 with 5 gate cycles -> gate_evt_cnt saturates at 3; rst asserted in WAKE -> no wake_ack, state ON.
